// File: rtl/ssd1306_pkg.sv
// Shared opcodes and FSM state encoding for the SSD1306 frame writer.
package ssd1306_pkg;

  localparam logic [7:0] SSD_CMD_COL_ADDR  = 8'h21;
  localparam logic [7:0] SSD_CMD_PAGE_ADDR = 8'h22;
  localparam logic [2:0] CMD_LAST_IDX      = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_CMD_WAIT,
    ST_READ,
    ST_LOAD,
    ST_DATA_WAIT
  } fw_state_e;

endpackage

// File: rtl/ssd1306_frame_writer.sv
// Streams a 6-byte addressing preamble then one full framebuffer frame
// to shift_reg over the start/data/ready handshake.
module ssd1306_frame_writer
  import ssd1306_pkg::*;
#(
  parameter  int unsigned COLS    = 128,
  parameter  int unsigned PAGES   = 4,
  parameter  int unsigned COL_OFS = 0,
  localparam int unsigned ADDR_W  = (COLS * PAGES > 1) ? $clog2(COLS * PAGES) : 1
) (
  input  logic              clk_in,
  input  logic              resetn,
  input  logic              enable,
  input  logic              frame_start,
  output logic              busy,
  output logic              frame_done,
  output logic              fb_rd,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [7:0]        fb_data,
  output logic              byte_start,
  output logic [7:0]        byte_out,
  input  logic              byte_ready,
  output logic              oled_dc
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * PAGES - 1);
  localparam logic [7:0]        COL_START = 8'(COL_OFS);
  localparam logic [7:0]        COL_END   = 8'(COL_OFS + COLS - 1);
  localparam logic [7:0]        PAGE_END  = 8'(PAGES - 1);

  fw_state_e         state_q, state_d;
  logic [2:0]        cmd_idx_q, cmd_idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              skip_q, skip_d;
  logic              fb_vld_q, fb_vld_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fb_rd_q, fb_rd_d;
  logic              start_q, start_d;
  logic [7:0]        out_q, out_d;
  logic              dc_q, dc_d;

  // Addressing preamble: column range then page range, horizontal mode set by init.
  function automatic logic [7:0] preamble(input logic [2:0] idx);
    case (idx)
      3'd0:    preamble = SSD_CMD_COL_ADDR;
      3'd1:    preamble = COL_START;
      3'd2:    preamble = COL_END;
      3'd3:    preamble = SSD_CMD_PAGE_ADDR;
      3'd4:    preamble = 8'h00;
      3'd5:    preamble = PAGE_END;
      default: preamble = 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    cmd_idx_d = cmd_idx_q;
    addr_d    = addr_q;
    skip_d    = skip_q;
    fb_vld_d  = fb_rd_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    fb_rd_d   = 1'b0;
    start_d   = 1'b0;
    out_d     = out_q;
    dc_d      = dc_q;

    case (state_q)
      ST_IDLE: begin
        if (frame_start && enable) begin
          state_d   = ST_CMD;
          cmd_idx_d = 3'd0;
          addr_d    = '0;
          busy_d    = 1'b1;
        end
      end
      ST_CMD: begin
        if (byte_ready) begin
          out_d   = preamble(cmd_idx_q);
          dc_d    = 1'b0;
          start_d = 1'b1;
          skip_d  = 1'b1;
          state_d = ST_CMD_WAIT;
        end
      end
      // shift_reg lowers ready one cycle after start, so the first wait cycle is ignored
      ST_CMD_WAIT: begin
        if (skip_q) begin
          skip_d = 1'b0;
        end else if (byte_ready) begin
          if (cmd_idx_q != CMD_LAST_IDX) begin
            cmd_idx_d = cmd_idx_q + 3'd1;
            state_d   = ST_CMD;
          end else begin
            addr_d  = '0;
            fb_rd_d = 1'b1;
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        state_d = ST_LOAD;
      end
      // fb_data is only valid the cycle after the read; later LOAD cycles keep the capture
      ST_LOAD: begin
        if (fb_vld_q) begin
          out_d = fb_data;
        end
        if (byte_ready) begin
          dc_d    = 1'b1;
          start_d = 1'b1;
          skip_d  = 1'b1;
          state_d = ST_DATA_WAIT;
        end
      end
      ST_DATA_WAIT: begin
        if (skip_q) begin
          skip_d = 1'b0;
        end else if (byte_ready) begin
          if (addr_q != LAST_ADDR) begin
            addr_d  = addr_q + ADDR_W'(1);
            fb_rd_d = 1'b1;
            state_d = ST_READ;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cmd_idx_q <= 3'd0;
      addr_q    <= '0;
      skip_q    <= 1'b0;
      fb_vld_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fb_rd_q   <= 1'b0;
      start_q   <= 1'b0;
      out_q     <= 8'h00;
      dc_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_idx_q <= cmd_idx_d;
      addr_q    <= addr_d;
      skip_q    <= skip_d;
      fb_vld_q  <= fb_vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fb_rd_q   <= fb_rd_d;
      start_q   <= start_d;
      out_q     <= out_d;
      dc_q      <= dc_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign fb_rd      = fb_rd_q;
  assign fb_addr    = addr_q;
  assign byte_start = start_q;
  assign byte_out   = out_q;
  assign oled_dc    = dc_q;

endmodule

// File: tb/tb_ssd1306_frame_writer.sv
// Directed scoreboard bench: default 128x4 instance plus a 16x2 offset-32 instance.
module tb_ssd1306_frame_writer;

  typedef struct packed {
    logic       dc;
    logic [7:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic resetn, enable;
  always #5 clk = ~clk;

  logic       fs0, busy0, fd0, rd0, bs0, rdy0, dc0;
  logic [8:0] addr0;
  logic [7:0] fbd0, bo0;
  logic       fs1, busy1, fd1, rd1, bs1, rdy1, dc1;
  logic [4:0] addr1;
  logic [7:0] fbd1, bo1;
  logic [4:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int starts0 = 0, starts1 = 0, dcnt0 = 0, done0 = 0, done1 = 0;
  logic [8:0] held0, held1;
  logic infl0 = 1'b0, infl1 = 1'b0;
  int base, dbase;

  ssd1306_frame_writer u_dut0 (
    .clk_in(clk), .resetn(resetn), .enable(enable), .frame_start(fs0),
    .busy(busy0), .frame_done(fd0), .fb_rd(rd0), .fb_addr(addr0), .fb_data(fbd0),
    .byte_start(bs0), .byte_out(bo0), .byte_ready(rdy0), .oled_dc(dc0)
  );

  ssd1306_frame_writer #(.COLS(16), .PAGES(2), .COL_OFS(32)) u_dut1 (
    .clk_in(clk), .resetn(resetn), .enable(enable), .frame_start(fs1),
    .busy(busy1), .frame_done(fd1), .fb_rd(rd1), .fb_addr(addr1), .fb_data(fbd1),
    .byte_start(bs1), .byte_out(bo1), .byte_ready(rdy1), .oled_dc(dc1)
  );

  // shift_reg model: ready drops the edge after start, then stays low 16 cycles
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdy0 <= 1'b1; cnt0 <= 5'd0;
    end else if (bs0) begin
      rdy0 <= 1'b0; cnt0 <= 5'd15;
    end else if (!rdy0) begin
      if (cnt0 == 5'd0) rdy0 <= 1'b1;
      else cnt0 <= cnt0 - 5'd1;
    end
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdy1 <= 1'b1; cnt1 <= 5'd0;
    end else if (bs1) begin
      rdy1 <= 1'b0; cnt1 <= 5'd15;
    end else if (!rdy1) begin
      if (cnt1 == 5'd0) rdy1 <= 1'b1;
      else cnt1 <= cnt1 - 5'd1;
    end
  end

  // framebuffer model, 1-cycle read latency
  always @(posedge clk) begin
    if (rd0) fbd0 <= addr0[7:0] ^ 8'hA5;
    if (rd1) fbd1 <= 8'(addr1) ^ 8'hA5;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic dc, input logic [7:0] b);
    exp_t e;
    e.dc = dc;
    e.b  = b;
    return e;
  endfunction

  task automatic push_frame0();
    q0.push_back(mk(1'b0, 8'h21)); q0.push_back(mk(1'b0, 8'h00));
    q0.push_back(mk(1'b0, 8'h7F)); q0.push_back(mk(1'b0, 8'h22));
    q0.push_back(mk(1'b0, 8'h00)); q0.push_back(mk(1'b0, 8'h03));
    for (int a = 0; a < 512; a++) q0.push_back(mk(1'b1, 8'(a) ^ 8'hA5));
  endtask

  task automatic push_frame1();
    q1.push_back(mk(1'b0, 8'h21)); q1.push_back(mk(1'b0, 8'h20));
    q1.push_back(mk(1'b0, 8'h2F)); q1.push_back(mk(1'b0, 8'h22));
    q1.push_back(mk(1'b0, 8'h00)); q1.push_back(mk(1'b0, 8'h01));
    for (int a = 0; a < 32; a++) q1.push_back(mk(1'b1, 8'(a) ^ 8'hA5));
  endtask

  task automatic pulse0();
    @(negedge clk); fs0 = 1'b1;
    @(negedge clk); fs0 = 1'b0;
  endtask

  task automatic wait_done0(input string tag);
    for (int i = 0; i < 20000 && !fd0; i++) @(negedge clk);
    chk(tag, 32'(fd0), 32'd1);
  endtask

  task automatic chk_reset0();
    chk("rst0_busy", 32'(busy0), 0);   chk("rst0_done", 32'(fd0), 0);
    chk("rst0_fb_rd", 32'(rd0), 0);    chk("rst0_fb_addr", 32'(addr0), 0);
    chk("rst0_start", 32'(bs0), 0);    chk("rst0_byte_out", 32'(bo0), 0);
    chk("rst0_dc", 32'(dc0), 0);
  endtask

  // byte monitor, instance 0
  initial forever begin
    @(negedge clk);
    if (!resetn) begin
      infl0 = 1'b0;
    end else begin
      if (bs0) begin
        starts0++;
        chk("start0_when_ready", 32'(rdy0), 1);
        chk("sb0_has_entry", 32'(q0.size() != 0), 1);
        if (q0.size() != 0) begin
          e0 = q0.pop_front();
          chk("byte0", 32'({dc0, bo0}), 32'(e0));
        end
        if (dc0) dcnt0++;
        held0 = {dc0, bo0};
        infl0 = 1'b1;
      end else if (infl0) begin
        if (rdy0) infl0 = 1'b0;
        else chk("hold0", 32'({dc0, bo0}), 32'(held0));
      end
      if (fd0) done0++;
    end
  end

  // byte monitor, instance 1
  initial forever begin
    @(negedge clk);
    if (!resetn) begin
      infl1 = 1'b0;
    end else begin
      if (bs1) begin
        starts1++;
        chk("start1_when_ready", 32'(rdy1), 1);
        chk("sb1_has_entry", 32'(q1.size() != 0), 1);
        if (q1.size() != 0) begin
          e1 = q1.pop_front();
          chk("byte1", 32'({dc1, bo1}), 32'(e1));
        end
        held1 = {dc1, bo1};
        infl1 = 1'b1;
      end else if (infl1) begin
        if (rdy1) infl1 = 1'b0;
        else chk("hold1", 32'({dc1, bo1}), 32'(held1));
      end
      if (fd1) done1++;
    end
  end

  initial begin
    resetn = 1'b0; enable = 1'b0; fs0 = 1'b0; fs1 = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset0();
    chk("rst1_busy", 32'(busy1), 0);
    chk("rst1_start", 32'(bs1), 0);

    // starts are dropped while not enabled
    resetn = 1'b1;
    @(negedge clk); fs0 = 1'b1; fs1 = 1'b1;
    @(negedge clk); fs0 = 1'b0; fs1 = 1'b0;
    repeat (100) @(negedge clk);
    chk("idle_starts0", 32'(starts0), 0);
    chk("idle_busy0", 32'(busy0), 0);
    chk("idle_starts1", 32'(starts1), 0);

    // full frame with first-byte latency and a colliding start
    enable = 1'b1;
    base = starts0;
    push_frame0();
    @(negedge clk); fs0 = 1'b1;
    @(posedge clk); #1 fs0 = 1'b0;
    chk("lat_busy", 32'(busy0), 1);
    chk("lat_no_early_start", 32'(bs0), 0);
    @(posedge clk); #1;
    chk("lat_first_start", 32'(bs0), 1);
    repeat (48) @(negedge clk);
    pulse0();
    enable = 1'b0;
    wait_done0("f1_done_seen");
    chk("f1_byte_count", 32'(starts0 - base), 518);
    chk("f1_queue_empty", 32'(q0.size()), 0);
    chk("f1_busy_low", 32'(busy0), 0);

    // start in the cycle after frame_done
    enable = 1'b1;
    base = starts0;
    push_frame0();
    @(negedge clk); fs0 = 1'b1;
    @(negedge clk); fs0 = 1'b0;
    chk("f1_done_count", 32'(done0), 1);
    chk("f2_busy", 32'(busy0), 1);
    wait_done0("f2_done_seen");
    chk("f2_byte_count", 32'(starts0 - base), 518);
    chk("f2_queue_empty", 32'(q0.size()), 0);

    // asynchronous reset at data byte 100
    dbase = dcnt0;
    push_frame0();
    pulse0();
    for (int i = 0; i < 5000 && (dcnt0 - dbase) < 100; i++) @(negedge clk);
    chk("mid_reached_100", 32'((dcnt0 - dbase) >= 100), 1);
    #2 resetn = 1'b0;
    #1;
    chk_reset0();
    q0.delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    base = starts0;
    push_frame0();
    pulse0();
    wait_done0("f3_done_seen");
    chk("f3_byte_count", 32'(starts0 - base), 518);
    chk("f3_queue_empty", 32'(q0.size()), 0);

    // small configuration
    push_frame1();
    @(negedge clk); fs1 = 1'b1;
    @(negedge clk); fs1 = 1'b0;
    for (int i = 0; i < 2000 && !fd1; i++) @(negedge clk);
    chk("small_done_seen", 32'(fd1), 1);
    chk("small_busy_low", 32'(busy1), 0);
    repeat (5) @(negedge clk);
    chk("small_byte_count", 32'(starts1), 38);
    chk("small_queue_empty", 32'(q1.size()), 0);
    chk("small_done_count", 32'(done1), 1);
    chk("total_done_count0", 32'(done0), 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
